// File: rtl/mem_pkg.sv
// mem_pkg: shared types and addressMode codes for the memory port arbiter
package mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;
    localparam logic [2:0] AM_B  = 3'd0;
    localparam logic [2:0] AM_H  = 3'd1;
    localparam logic [2:0] AM_W  = 3'd2;
    localparam logic [2:0] AM_BU = 3'd4;
    localparam logic [2:0] AM_HU = 3'd5;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and data requests
module mem_arb_pick
    import mem_pkg::*;
(
    input  logic   if_req,
    input  logic   d_req,
    input  logic   starved,
    output logic   gnt,
    output owner_t owner
);
    assign gnt   = if_req | d_req;
    assign owner = (d_req && !(if_req && starved)) ? OWN_D : OWN_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data memory between instruction fetch and the data port
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int width        = 32,
    parameter int adrWidth     = 24,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [adrWidth-1:0] if_addr,
    output logic [width-1:0]    if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [adrWidth-1:0] d_addr,
    input  logic [width-1:0]    d_wdata,
    input  logic [2:0]          d_mode,
    output logic [width-1:0]    d_rdata,
    output logic                d_valid,
    output logic                err,
    output logic                mem_req,
    output logic                mem_we,
    output logic [adrWidth-1:0] mem_addr,
    output logic [width-1:0]    mem_wdata,
    output logic [2:0]          mem_mode,
    input  logic [width-1:0]    mem_rdata,
    input  logic                mem_ack,
    output logic                if_stall,
    output logic                d_stall
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state, state_n;
    owner_t          owner, win;
    logic            gnt, take, fin, tout, starved;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   tcnt;
    logic [width-1:0] rd;

    assign starved  = starve_cnt == SW'(STARVE_LIMIT);
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    mem_arb_pick u_pick (
        .if_req  (if_req),
        .d_req   (d_req),
        .starved (starved),
        .gnt     (gnt),
        .owner   (win)
    );

    // next state, accept/finish strobes and the data returned to the owner
    always_comb begin
        take    = state == IDLE && gnt;
        tout    = state == BUSY && !mem_ack && tcnt == TW'(TIMEOUT - 1);
        fin     = state == BUSY && (mem_ack || tout);
        rd      = (mem_we || tout) ? '0 : mem_rdata;
        state_n = take ? BUSY : fin ? DONE : state == DONE ? IDLE : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // memory-side request registers, counters and completion pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_IF;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_mode   <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            err        <= 1'b0;
            starve_cnt <= '0;
            tcnt       <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
            if (state == IDLE)
                starve_cnt <= (!if_req || win == OWN_IF) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
            if (take) begin
                owner     <= win;
                mem_req   <= 1'b1;
                mem_we    <= win == OWN_D ? d_we : 1'b0;
                mem_addr  <= win == OWN_D ? d_addr : if_addr;
                mem_wdata <= win == OWN_D ? d_wdata : '0;
                mem_mode  <= win == OWN_D ? d_mode : AM_W;
                tcnt      <= '0;
            end
            if (state == BUSY) tcnt <= tcnt + 1'b1;
            if (fin) begin
                mem_req <= 1'b0;
                err     <= tout;
                if (owner == OWN_D) begin
                    d_rdata <= rd;
                    d_valid <= 1'b1;
                end else begin
                    if_rdata <= rd;
                    if_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus, bench memory and a transaction-level model checked every cycle
module tb_mem_port_arbiter;
    logic        clk = 0, rst = 1;
    logic        if_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
    logic [23:0] if_addr = 0, d_addr = 0;
    logic [31:0] d_wdata = 0, mem_rdata = 0;
    logic [2:0]  d_mode = 3'd2;
    logic [31:0] if_rdata, d_rdata, mem_wdata;
    logic        if_valid, d_valid, err, mem_req, mem_we, if_stall, d_stall;
    logic [23:0] mem_addr;
    logic [2:0]  mem_mode;

    int checks = 0, errors = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mode(d_mode),
        .d_rdata(d_rdata), .d_valid(d_valid), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mode(mem_mode), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .if_stall(if_stall), .d_stall(d_stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // bench memory: word store keyed by address, ack after mem_delay waits (-1 = never)
    logic [31:0] marr [logic [23:0]];
    int  mem_delay = 0, wcnt = 0;
    bit  stray = 0;
    always @(posedge clk) begin
        #1;
        if (stray) begin
            mem_ack = 1;
            stray = 0;
        end else if (mem_req && !mem_ack && mem_delay >= 0) begin
            if (wcnt == mem_delay) begin
                mem_ack = 1;
                wcnt = 0;
                if (mem_we) marr[mem_addr] = mem_wdata;
                mem_rdata = mem_we ? 32'h0BAD0BAD : marr.exists(mem_addr) ? marr[mem_addr] : {8'hA5, mem_addr};
            end else begin
                wcnt++;
                mem_ack = 0;
            end
        end else begin
            mem_ack = 0;
            wcnt = 0;
        end
    end

    // transaction model: one access in flight, grant on a free cycle, completion the cycle after ack or 255 unanswered cycles
    bit          busy = 0, done_n = 0, done_now, e_d, e_we, e_err;
    int          starve = 0, bcnt = 0, gcnt = 0;
    logic [31:0] gbits = 0, e_rd = 0, e_wdata = 0;
    logic [23:0] e_addr = 0;
    logic [2:0]  e_mode = 0;
    always @(negedge clk) begin
        if (rst) begin
            busy = 0; done_n = 0; starve = 0; bcnt = 0;
        end else begin
            done_now = done_n;
            done_n = 0;
            chk("if_stall", if_stall, if_req && !if_valid);
            chk("d_stall", d_stall, d_req && !d_valid);
            chk("if_valid", if_valid, done_now && !e_d);
            chk("d_valid", d_valid, done_now && e_d);
            chk("err", err, done_now && e_err);
            if (done_now) chk(e_d ? "d_rdata" : "if_rdata", e_d ? d_rdata : if_rdata, e_rd);
            chk("mem_req", mem_req, busy);
            if (busy) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_we", mem_we, e_we);
                chk("mem_mode", mem_mode, e_mode);
                if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
                bcnt++;
                if (mem_ack) begin
                    done_n = 1; e_err = 0; e_rd = e_we ? 0 : mem_rdata; busy = 0;
                end else if (bcnt == 255) begin
                    done_n = 1; e_err = 1; e_rd = 0; busy = 0;
                end
            end else if (!done_now && (if_req || d_req)) begin
                e_d = d_req && !(if_req && starve == 4);
                starve = (!e_d || !if_req) ? 0 : (starve < 4 ? starve + 1 : 4);
                e_addr  = e_d ? d_addr : if_addr;
                e_we    = e_d ? d_we : 0;
                e_mode  = e_d ? d_mode : 3'd2;
                e_wdata = d_wdata;
                busy = 1; bcnt = 0;
                gbits = {gbits[30:0], e_d};
                gcnt++;
            end else if (!done_now) begin
                starve = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input bit is_d, output int n, output int sc);
        n = 0; sc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            if (if_stall) sc++;
            if (is_d ? d_valid : if_valid) return;
        end
        checks++;
        errors++;
        $display("FAIL valid_wait: no valid pulse within 400 cycles");
    endtask

    int n, sc, vc, rq;
    initial begin
        tick; tick;
        @(negedge clk);
        chk("rst_mem_req", mem_req, 0);   chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_mode", mem_mode, 0); chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);   chk("rst_if_valid", if_valid, 0);
        chk("rst_d_valid", d_valid, 0);   chk("rst_err", err, 0);
        tick; rst = 0;

        d_req = 1; d_we = 1; d_addr = 24'h10; d_wdata = 32'hDEADBEEF; d_mode = 3'd2;
        wait_valid(1, n, sc);
        chk("sw_latency", n, 3); chk("sw_rdata", d_rdata, 0);
        tick; d_req = 0; d_we = 0;
        tick; d_req = 1;
        wait_valid(1, n, sc);
        chk("lw_latency", n, 3); chk("lw_rdata", d_rdata, 32'hDEADBEEF);
        tick; d_req = 0;

        mem_delay = 5; if_addr = 24'h100;
        tick; if_req = 1;
        wait_valid(0, n, sc);
        chk("if_latency", n, 8); chk("if_stall_cycles", sc, 7); chk("if_rdata_val", if_rdata, 32'hA5000100);
        tick; if_req = 0; mem_delay = 0;

        tick; gcnt = 0; gbits = 0;
        if_addr = 24'h200; d_addr = 24'h300; if_req = 1; d_req = 1;
        repeat (18) tick;
        if_req = 0; d_req = 0;
        chk("starve_grants", gcnt, 6); chk("starve_order", gbits[5:0], 6'b111101);

        mem_delay = -1; d_addr = 24'h40;
        tick; d_req = 1;
        wait_valid(1, n, sc);
        chk("tout_latency", n, 257); chk("tout_err", err, 1); chk("tout_rdata", d_rdata, 0);
        tick; d_req = 0;

        tick; d_req = 1;
        repeat (3) tick;
        rst = 1; d_req = 0;
        tick; rst = 0;
        vc = 0; rq = 0;
        repeat (4) begin
            @(negedge clk);
            vc += int'(d_valid) + int'(if_valid);
            rq += int'(mem_req);
        end
        chk("rst_busy_valids", vc, 0); chk("rst_busy_mem_req", rq, 0);
        mem_delay = 0; d_addr = 24'h10;
        tick; d_req = 1;
        wait_valid(1, n, sc);
        chk("post_rst_latency", n, 3); chk("post_rst_rdata", d_rdata, 32'hDEADBEEF);
        tick; d_req = 0;

        tick; stray = 1;
        vc = 0; rq = 0;
        repeat (4) begin
            @(negedge clk);
            vc += int'(d_valid) + int'(if_valid) + int'(err);
            rq += int'(mem_req);
        end
        chk("stray_valids", vc, 0); chk("stray_mem_req", rq, 0);
        tick; tick;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
